// File: rtl/jk_excitation_driver.sv
`default_nettype none
// ============================================================================
// Module      : jk_excitation_driver
// Description : Drive side of an N-bit JK flip-flop bank. Accepts a target
//               word and derives per-bit J/K excitation from the fed-back Q.
//               It applies the excitation for one clock, then checks the
//               bank. It re-drives on mismatch and reports done or err.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_excitation_driver #(
    parameter int N           = 4,
    parameter int TOGGLE_MODE = 0,
    parameter int MAX_RETRY   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    output logic         in_ready,
    input  logic [N-1:0] q_fb,
    output logic [N-1:0] j_out,
    output logic [N-1:0] k_out,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [N-1:0] mismatch
);

    // Retry budget is held in a 4-bit counter (0..15).
    localparam logic [3:0] C_MAX_RETRY = 4'(MAX_RETRY);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] target_q, target_d;
    logic [N-1:0] j_q, j_d;
    logic [N-1:0] k_q, k_d;
    logic [N-1:0] mismatch_q, mismatch_d;
    logic [3:0]   retry_q, retry_d;
    logic         in_ready_q, in_ready_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         err_q, err_d;

    logic [N-1:0] exc_target;
    logic [N-1:0] exc_j;
    logic [N-1:0] exc_k;
    logic [N-1:0] diff;

    // Per-bit excitation: differing bits get set/reset or toggle, equal
    // bits hold. In IDLE the incoming word is the target, otherwise the
    // latched one.
    always_comb begin
        exc_target = (state_q == ST_IDLE) ? in_data : target_q;
        diff       = q_fb ^ exc_target;
        if (TOGGLE_MODE != 0) begin
            exc_j = diff;
            exc_k = diff;
        end else begin
            exc_j = diff & exc_target;
            exc_k = diff & ~exc_target;
        end
    end

    // Next-state and registered-output logic for the IDLE/DRIVE/CHECK FSM.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        j_d        = '0;
        k_d        = '0;
        mismatch_d = mismatch_q;
        retry_d    = retry_q;
        in_ready_d = in_ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b0;
                if (in_valid && in_ready_q) begin
                    target_d   = in_data;
                    j_d        = exc_j;
                    k_d        = exc_k;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    retry_d    = 4'd0;
                    state_d    = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                // Excitation was valid for this whole cycle; the bank has
                // sampled it at this edge, so release J/K.
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                mismatch_d = q_fb ^ target_q;
                if (q_fb == target_q) begin
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    in_ready_d = 1'b1;
                    state_d    = ST_IDLE;
                end else if (retry_q < C_MAX_RETRY) begin
                    retry_d = retry_q + 4'd1;
                    j_d     = exc_j;
                    k_d     = exc_k;
                    state_d = ST_DRIVE;
                end else begin
                    err_d      = 1'b1;
                    busy_d     = 1'b0;
                    in_ready_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                busy_d     = 1'b0;
                in_ready_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset leaves J=K=0 so the bank holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            target_q   <= '0;
            j_q        <= '0;
            k_q        <= '0;
            mismatch_q <= '0;
            retry_q    <= 4'd0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            j_q        <= j_d;
            k_q        <= k_d;
            mismatch_q <= mismatch_d;
            retry_q    <= retry_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign in_ready = in_ready_q;
    assign j_out    = j_q;
    assign k_out    = k_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign mismatch = mismatch_q;

endmodule
`default_nettype wire

// File: tb/tb_jk_excitation_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_excitation_driver
// Description : Self-checking bench for jk_excitation_driver. Two instances
//               (set/reset mode with two retries, toggle mode with none)
//               each drive a behavioural JK bank with optional stuck-at-0
//               bits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_excitation_driver;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sel;
    logic         tb_valid;
    logic [N-1:0] tb_data;
    logic         load_en;
    logic [N-1:0] ld_val;
    logic [N-1:0] stuck0, stuck1;
    logic [N-1:0] bank0, bank1;

    logic         in_valid0, in_valid1;
    logic [N-1:0] q_fb0, q_fb1;
    logic         ready0, ready1, busy0, busy1, done0, done1, err0, err1;
    logic [N-1:0] j0, j1, k0, k1, mm0, mm1;

    logic         obs_ready, obs_busy, obs_done, obs_err;
    logic [N-1:0] obs_j, obs_k, obs_mm;

    logic [N-1:0] mq [0:1];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign in_valid0 = tb_valid & ~sel;
    assign in_valid1 = tb_valid & sel;
    assign q_fb0     = bank0 & ~stuck0;
    assign q_fb1     = bank1 & ~stuck1;

    assign obs_ready = sel ? ready1 : ready0;
    assign obs_busy  = sel ? busy1  : busy0;
    assign obs_done  = sel ? done1  : done0;
    assign obs_err   = sel ? err1   : err0;
    assign obs_j     = sel ? j1     : j0;
    assign obs_k     = sel ? k1     : k0;
    assign obs_mm    = sel ? mm1    : mm0;

    jk_excitation_driver #(.N(N), .TOGGLE_MODE(0), .MAX_RETRY(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_data(tb_data),
        .in_ready(ready0), .q_fb(q_fb0), .j_out(j0), .k_out(k0),
        .busy(busy0), .done(done0), .err(err0), .mismatch(mm0)
    );

    jk_excitation_driver #(.N(N), .TOGGLE_MODE(1), .MAX_RETRY(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_data(tb_data),
        .in_ready(ready1), .q_fb(q_fb1), .j_out(j1), .k_out(k1),
        .busy(busy1), .done(done1), .err(err1), .mismatch(mm1)
    );

    // Plain JK truth table for one bit.
    function automatic logic jk_bit(input logic q, input logic j, input logic k);
        case ({j, k})
            2'b00:   return q;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return ~q;
        endcase
    endfunction

    // Behavioural JK banks with a load port for presetting.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (load_en && !sel) bank0[i] <= ld_val[i];
            else                 bank0[i] <= jk_bit(bank0[i], j0[i], k0[i]);
            if (load_en && sel)  bank1[i] <= ld_val[i];
            else                 bank1[i] <= jk_bit(bank1[i], j1[i], k1[i]);
        end
    end

    // Expected excitation from the bit-by-bit rule table.
    function automatic void expect_exc(input logic [N-1:0] q, input logic [N-1:0] t,
                                       input bit tog, output logic [N-1:0] ej,
                                       output logic [N-1:0] ek);
        for (int i = 0; i < N; i++) begin
            if (q[i] == t[i])  begin ej[i] = 1'b0; ek[i] = 1'b0; end
            else if (tog)      begin ej[i] = 1'b1; ek[i] = 1'b1; end
            else if (t[i])     begin ej[i] = 1'b1; ek[i] = 1'b0; end
            else               begin ej[i] = 1'b0; ek[i] = 1'b1; end
        end
    endfunction

    task automatic load_bank(input logic [N-1:0] v);
        ld_val  = v;
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
        mq[sel] = v & ~(sel ? stuck1 : stuck0);
    endtask

    // One transaction on the selected instance, checked cycle by cycle.
    // Called at a negedge with the driver idle.
    task automatic run_txn(input logic [N-1:0] t, input bit glitch, input string tag);
        logic [N-1:0] q, ej, ek, stk;
        bit tog, fin;
        int maxr;
        tog  = sel;
        maxr = sel ? 0 : 2;
        stk  = sel ? stuck1 : stuck0;
        q    = mq[sel];
        fin  = 1'b0;
        n_checks++;
        if (obs_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_before_accept: got %0b want 1", tag, obs_ready);
        end
        tb_valid = 1'b1;
        tb_data  = t;
        @(negedge clk);
        if (glitch) tb_data = ~t;
        else        tb_valid = 1'b0;
        for (int a = 0; a <= maxr && !fin; a++) begin
            expect_exc(q, t, tog, ej, ek);
            n_checks++;
            if ({obs_j, obs_k} !== {ej, ek}) begin
                n_fail++;
                $display("FAIL %s drive%0d_jk: got j=%b k=%b want j=%b k=%b",
                         tag, a, obs_j, obs_k, ej, ek);
            end
            n_checks++;
            if ({obs_busy, obs_ready, obs_done, obs_err} !== 4'b1000) begin
                n_fail++;
                $display("FAIL %s drive%0d_status: got busy/ready/done/err=%b want 1000",
                         tag, a, {obs_busy, obs_ready, obs_done, obs_err});
            end
            @(negedge clk);
            tb_valid = 1'b0;
            n_checks++;
            if ({obs_j, obs_k, obs_busy, obs_ready, obs_done, obs_err} !== {8'h00, 4'b1000}) begin
                n_fail++;
                $display("FAIL %s check%0d_phase: got j=%b k=%b bsy/rdy/dn/er=%b want j=0000 k=0000 1000",
                         tag, a, obs_j, obs_k, {obs_busy, obs_ready, obs_done, obs_err});
            end
            // Healthy bits reach the target; stuck bits read as 0.
            q = t & ~stk;
            @(negedge clk);
            n_checks++;
            if (obs_mm !== (q ^ t)) begin
                n_fail++;
                $display("FAIL %s mismatch%0d: got %b want %b", tag, a, obs_mm, q ^ t);
            end
            if (q == t) begin
                fin = 1'b1;
                n_checks++;
                if ({obs_busy, obs_ready, obs_done, obs_err} !== 4'b0110) begin
                    n_fail++;
                    $display("FAIL %s done_pulse: got busy/ready/done/err=%b want 0110",
                             tag, {obs_busy, obs_ready, obs_done, obs_err});
                end
            end else if (a == maxr) begin
                fin = 1'b1;
                n_checks++;
                if ({obs_busy, obs_ready, obs_done, obs_err} !== 4'b0101) begin
                    n_fail++;
                    $display("FAIL %s err_pulse: got busy/ready/done/err=%b want 0101",
                             tag, {obs_busy, obs_ready, obs_done, obs_err});
                end
            end
        end
        mq[sel] = q;
        @(negedge clk);
        n_checks++;
        if ({obs_ready, obs_done, obs_err, obs_j, obs_k} !== {3'b100, 8'h00}) begin
            n_fail++;
            $display("FAIL %s after_pulse: got rdy/dn/er=%b j=%b k=%b want 100 0000 0000",
                     tag, {obs_ready, obs_done, obs_err}, obs_j, obs_k);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        tb_valid = 1'b0;
        tb_data  = '0;
        load_en  = 1'b0;
        ld_val   = '0;
        stuck0   = '0;
        stuck1   = '0;
        sel      = 1'b0;
        @(negedge clk);
        load_bank(4'b0000);
        sel = 1'b1;
        load_bank(4'b0000);
        sel = 1'b0;
        n_checks++;
        if ({ready0, busy0, done0, err0, j0, k0, mm0, ready1, busy1, done1, err1, j1, k1, mm1} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got r0=%b b0=%b d0=%b e0=%b j0=%b k0=%b m0=%b r1=%b b1=%b d1=%b e1=%b j1=%b k1=%b m1=%b want all 0",
                     ready0, busy0, done0, err0, j0, k0, mm0, ready1, busy1, done1, err1, j1, k1, mm1);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({ready0, ready1} !== 2'b00) begin
            n_fail++;
            $display("FAIL ready_before_edge: got %b want 00", {ready0, ready1});
        end
        @(negedge clk);
        n_checks++;
        if ({ready0, ready1, busy0, busy1} !== 4'b1100) begin
            n_fail++;
            $display("FAIL ready_after_release: got rdy0/rdy1/bsy0/bsy1=%b want 1100",
                     {ready0, ready1, busy0, busy1});
        end
    endtask

    task automatic test_plan_vectors();
        sel = 1'b0;
        load_bank(4'b0000);
        run_txn(4'b1010, 1'b0, "set_1010");
        run_txn(4'b0110, 1'b0, "setreset_0110");
        run_txn(4'b0110, 1'b0, "equal_0110");
        sel = 1'b1;
        load_bank(4'b1010);
        run_txn(4'b0110, 1'b0, "toggle_0110");
        sel = 1'b0;
    endtask

    task automatic test_stuck_retry();
        sel    = 1'b0;
        stuck0 = 4'b0001;
        load_bank(4'b0000);
        run_txn(4'b0001, 1'b0, "stuck_retry2");
        stuck0 = 4'b0000;
        load_bank(4'b0000);
        sel    = 1'b1;
        stuck1 = 4'b0100;
        load_bank(4'b0000);
        run_txn(4'b0110, 1'b0, "stuck_retry0");
        stuck1 = 4'b0000;
        load_bank(4'b0000);
        sel = 1'b0;
    endtask

    task automatic test_ignore_valid();
        sel = 1'b0;
        load_bank(4'(($urandom_range(0, 15))));
        run_txn(4'b1100, 1'b1, "valid_during_drive");
        run_txn(4'b0011, 1'b1, "valid_during_drive2");
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        for (int i = 0; i < 4; i++) run_txn(4'(($urandom_range(0, 15))), 1'b0, "b2b");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            sel = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                if (sel) stuck1 = 4'(($urandom_range(1, 15)));
                else     stuck0 = 4'(($urandom_range(1, 15)));
            end
            load_bank(4'(($urandom_range(0, 15))));
            run_txn(4'(($urandom_range(0, 15))), 1'($urandom_range(0, 1)), "random");
            if ((sel ? stuck1 : stuck0) != '0) begin
                stuck0 = '0;
                stuck1 = '0;
                load_bank(4'b0000);
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        load_bank(4'b0000);
        tb_valid = 1'b1;
        tb_data  = 4'b1111;
        @(negedge clk);
        tb_valid = 1'b0;
        n_checks++;
        if ({j0, busy0} !== 5'b11111) begin
            n_fail++;
            $display("FAIL midrst_drive: got j=%b busy=%b want 1111 1", j0, busy0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({j0, k0, busy0, done0, err0, ready0} !== 12'h000) begin
            n_fail++;
            $display("FAIL midrst_async_clear: got j=%b k=%b bsy/dn/er/rdy=%b want all 0",
                     j0, k0, {busy0, done0, err0, ready0});
        end
        @(negedge clk);
        n_checks++;
        if ({q_fb0, j0, k0, done0, err0} !== 14'h0) begin
            n_fail++;
            $display("FAIL midrst_bank_hold: got q=%b j=%b k=%b dn=%b er=%b want 0000 0000 0000 0 0",
                     q_fb0, j0, k0, done0, err0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({ready0, mm0} !== 5'b10000) begin
            n_fail++;
            $display("FAIL midrst_release: got ready=%b mismatch=%b want 1 0000", ready0, mm0);
        end
        run_txn(4'b1111, 1'b0, "after_reset_1111");
    endtask

    initial begin
        test_reset();
        test_plan_vectors();
        test_stuck_retry();
        test_ignore_valid();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jk_excitation_driver.md
Name: jk_excitation_driver

Overview:
- Drive side of a JK flip-flop register bank: accepts a target word, derives per-bit J/K excitation from the bank's current Q, and applies it for one clock.
- Checks that the bank reached the target; retries on mismatch and reports done or error.
- Sits between a control sequencer (valid/ready) and an N-bit bank of jkff cells, with Q fed back.

Parameters:
- N, 4, width of the JK register bank, in bits.
- TOGGLE_MODE, 0, 0: changing bits use set/reset (J=1,K=0 / J=0,K=1); 1: changing bits use toggle (J=1,K=1).
- MAX_RETRY, 2, number of re-drive attempts after the first failed check (0..15).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  target word valid.
- in_data  in  N  target Q value.
- in_ready  out  1  driver idle and able to accept.
- q_fb  in  N  Q outputs of the JK bank.
- j_out  out  N  J inputs to the bank.
- k_out  out  N  K inputs to the bank.
- busy  out  1  a transaction is in progress.
- done  out  1  one-cycle pulse: bank matches target.
- err  out  1  one-cycle pulse: retries exhausted.
- mismatch  out  N  bits of q_fb differing from target at the last CHECK.

Behaviour:
- Reset (asynchronous, immediate on rst_n low):
  - j_out, k_out, busy, done, err, mismatch, in_ready all 0.
  - State IDLE; retry count 0; target register 0.
  - in_ready rises on the first clk edge after rst_n deasserts.
- All outputs are registered.
- Excitation per bit i (q = q_fb[i], t = target[i]):
  - q=t: J=0, K=0 (hold).
  - q=0, t=1: J=1, K=0, or J=1, K=1 when TOGGLE_MODE=1.
  - q=1, t=0: J=0, K=1, or J=1, K=1 when TOGGLE_MODE=1.
- States: IDLE, DRIVE, CHECK.
- IDLE:
  - j_out = k_out = 0; in_ready = 1; busy = 0.
  - On an edge with in_valid & in_ready: latch target <= in_data; register j_out/k_out from excitation(q_fb, in_data); in_ready <= 0; busy <= 1; retry <= 0; go to DRIVE.
- DRIVE (exactly 1 cycle):
  - J/K are held stable for the whole cycle; the bank samples them at the next edge.
  - At that edge, j_out <= 0 and k_out <= 0; go to CHECK.
- CHECK (1 cycle):
  - At the edge, mismatch <= q_fb ^ target.
  - If equal: done <= 1 for one cycle; busy <= 0; in_ready <= 1; go to IDLE.
  - Else if retry < MAX_RETRY: retry++; j_out/k_out <= excitation(q_fb, target); go to DRIVE.
  - Else: err <= 1 for one cycle; busy <= 0; in_ready <= 1; go to IDLE.
- Latency, with no retries:
  - Acceptance edge E0; J/K valid during E0..E1; CHECK at E2.
  - done is high in the cycle after E2.
  - Each retry adds 2 cycles.
- done and err are never high together, and never high outside the cycle after a CHECK.
- mismatch holds its value until the next CHECK or reset.
- in_valid while in_ready = 0 is ignored; no queuing.
- Target equal to current Q: one DRIVE with J=K=0, then done.
- MAX_RETRY = 0: the first failing CHECK gives err.
- Reset mid-transaction:
  - Outputs cleared immediately; the transaction is abandoned with no done/err.
  - J=K=0 while in reset, so the bank holds.

Test Plan:
- N=4, TOGGLE_MODE=0, bank Q=0000, send 1010 -> j_out=1010, k_out=0000 for exactly 1 cycle; bank Q=1010; done pulses 2 cycles after the accept edge; mismatch=0000.
- Bank Q=1010, send 0110 -> j_out=0100, k_out=1000; done; Q=0110. Repeat with TOGGLE_MODE=1 -> j_out=k_out=1100; same final Q.
- Bank Q=0110, send 0110 -> j_out=k_out=0000; done after 2 cycles; Q unchanged.
- Stuck-at-0 bit 0 forced in the bank model, send 0001, MAX_RETRY=2 -> 3 DRIVE cycles; err pulse at cycle 6 after accept; mismatch=0001; done never asserts.
- in_valid asserted with a new value during DRIVE -> ignored; in_ready=0; the original target completes.
- rst_n low during DRIVE -> j_out, k_out, busy, done, err go to 0 without a clock edge. After release, in_ready is 1 at the next edge, and a new 1111 transaction completes normally.
